block_sync: RTL
===============

BLOCK_SYNC -- requirements
Module: block_sync

Interface
REQ-001 Parameter LEN_CODED_BLOCK, default 66: width of the coded block and of the raw input word.
REQ-002 Parameter NB_SH_LOCK, default 64: consecutive valid sync headers required to acquire lock.
REQ-003 Parameter NB_WINDOW, default 1024: enabled words per invalid-header monitoring window while locked.
REQ-004 Parameter NB_INVALID_MAX, default 65: invalid headers within one window that cause loss of lock.
REQ-005 i_clock  input  1  clock; all state updates on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_enable  input  1  qualifies i_data; when low, all state SHALL hold and the word SHALL NOT be evaluated.
REQ-008 i_data  input  LEN_CODED_BLOCK  raw unaligned word; bit LEN_CODED_BLOCK-1 is the earliest bit in time.
REQ-009 o_data  output  LEN_CODED_BLOCK  aligned coded block to the downstream descrambler; sync header in the two MSBs.
REQ-010 o_valid  output  1  o_data holds an aligned block captured while locked.
REQ-011 o_block_lock  output  1  block lock status.
REQ-012 o_slip_offset  output  7  current alignment offset, 0..LEN_CODED_BLOCK-1.

Function
REQ-013 On each enabled word: prev_word <= i_data; window = {prev_word, i_data}, 132 bits.
REQ-014 Candidate block = window[131-offset -: 66]; header = candidate[65:64]; valid iff 2'b01 or 2'b10.
REQ-015 The first enabled word after reset SHALL only load prev_word (prime); it SHALL NOT be evaluated or update counters.
REQ-016 States: HUNT, LOCKED; reset state HUNT.
REQ-017 HUNT, valid header: sh_cnt += 1; when sh_cnt reaches NB_SH_LOCK -> LOCKED, sh_cnt, win_cnt and inv_cnt cleared.
REQ-018 HUNT, invalid header: offset = (offset+1) mod 66 (65 wraps to 0); sh_cnt cleared; stay in HUNT.
REQ-019 LOCKED: every evaluated word increments win_cnt; every invalid header increments inv_cnt.
REQ-020 LOCKED, inv_cnt reaches NB_INVALID_MAX -> HUNT, offset+1 mod 66, all counters cleared.
REQ-021 LOCKED, win_cnt reaches NB_WINDOW with inv_cnt < NB_INVALID_MAX -> win_cnt and inv_cnt cleared; stay LOCKED.
REQ-022 If the 65th invalid header falls on the 1024th word, loss of lock SHALL take precedence over window clear.
REQ-023 o_block_lock SHALL be registered and SHALL reflect the state one cycle after the deciding word.
REQ-024 o_data <= candidate on every evaluated word; o_valid <= 1 iff the word was evaluated while state is LOCKED (before that word's transition), else 0.
REQ-025 Latency: aligned block appears on o_data one clock after the enabled i_data word completing it.
REQ-026 Counter widths SHALL hold NB_WINDOW and NB_INVALID_MAX without overflow; no counter SHALL wrap.

Reset
REQ-027 On i_reset: state HUNT, offset 0, sh_cnt/win_cnt/inv_cnt 0, prime flag cleared, prev_word 0, o_data 0, o_valid 0, o_block_lock 0, o_slip_offset 0.
REQ-028 Reset asserted mid-lock SHALL override all other activity in that cycle, including i_enable.

Verification
REQ-029 Blocks header 2'b01, payload zero, offset 0, i_enable=1 -> o_block_lock=1 one cycle after 64th evaluated word; o_slip_offset=0; o_valid=1 thereafter.
REQ-030 Same stream delayed 13 bits -> 13 slips, then lock after 64 valid headers; o_slip_offset=13; o_data[65:64]=2'b01.
REQ-031 Locked; 64 invalid headers within one window -> lock held; 65th invalid -> o_block_lock=0 next cycle, o_slip_offset increments by 1.
REQ-032 Locked; 64 invalid, valid words to complete 1024-word window, then 64 more invalid -> lock held throughout.
REQ-033 HUNT with sh_cnt=30, i_enable low 10 cycles -> sh_cnt, offset, outputs unchanged; o_valid=0.
REQ-034 Offset 65 plus invalid header -> offset 0; i_reset while locked -> all REQ-027 values next cycle.

Source files
------------

// File: rtl/block_sync.sv
// Block synchronizer for 66-bit coded blocks: hunts for a stable sync-header
// alignment, then monitors invalid headers per window to detect loss of lock.
module block_sync #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_SH_LOCK      = 64,
    parameter int NB_WINDOW       = 1024,
    parameter int NB_INVALID_MAX  = 65
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_block_lock,
    output logic [6:0]                 o_slip_offset
);

    localparam int L     = LEN_CODED_BLOCK;
    localparam int SH_W  = $clog2(NB_SH_LOCK + 1);
    localparam int WIN_W = $clog2(NB_WINDOW + 1);
    localparam int INV_W = $clog2(NB_INVALID_MAX + 1);
    localparam int IDX_W = $clog2(2 * L);

    localparam logic [SH_W-1:0]  SH_LOCK_C  = SH_W'(NB_SH_LOCK);
    localparam logic [WIN_W-1:0] WINDOW_C   = WIN_W'(NB_WINDOW);
    localparam logic [INV_W-1:0] INV_MAX_C  = INV_W'(NB_INVALID_MAX);
    localparam logic [6:0]       OFS_LAST_C = 7'(L - 1);
    localparam logic [IDX_W-1:0] TOP_IDX_C  = IDX_W'(2 * L - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       ofs_q, ofs_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic             primed_q, primed_d;
    logic [L-1:0]     prev_q, prev_d;
    logic [L-1:0]     data_q, data_d;
    logic             valid_q, valid_d;

    logic [2*L-1:0]   window;
    logic [IDX_W-1:0] base_idx;
    logic [L-1:0]     candidate;
    logic             hdr_ok;
    logic             evaluate;
    logic [6:0]       ofs_inc;
    logic [SH_W-1:0]  sh_inc;
    logic [WIN_W-1:0] win_inc;
    logic [INV_W-1:0] inv_inc;

    // Offset counts from the earliest bit of the previous word.
    assign window    = {prev_q, i_data};
    assign base_idx  = TOP_IDX_C - IDX_W'(ofs_q);
    assign candidate = window[base_idx -: L];
    assign hdr_ok    = candidate[L-1] ^ candidate[L-2];
    assign evaluate  = i_enable & primed_q;

    assign ofs_inc = (ofs_q == OFS_LAST_C) ? 7'd0 : ofs_q + 7'd1;
    assign sh_inc  = sh_cnt_q + 1'b1;
    assign win_inc = win_cnt_q + 1'b1;
    assign inv_inc = inv_cnt_q + {{(INV_W-1){1'b0}}, ~hdr_ok};

    always_comb begin
        state_d   = state_q;
        ofs_d     = ofs_q;
        sh_cnt_d  = sh_cnt_q;
        win_cnt_d = win_cnt_q;
        inv_cnt_d = inv_cnt_q;
        primed_d  = primed_q;
        prev_d    = prev_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        if (i_enable) begin
            prev_d   = i_data;
            primed_d = 1'b1;
        end

        if (evaluate) begin
            data_d  = candidate;
            valid_d = (state_q == LOCKED);
            unique case (state_q)
                HUNT: begin
                    if (!hdr_ok) begin
                        ofs_d    = ofs_inc;
                        sh_cnt_d = '0;
                    end else if (sh_inc == SH_LOCK_C) begin
                        state_d   = LOCKED;
                        sh_cnt_d  = '0;
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
                LOCKED: begin
                    // Loss of lock wins over the end-of-window clear.
                    if (inv_inc == INV_MAX_C) begin
                        state_d   = HUNT;
                        ofs_d     = ofs_inc;
                        sh_cnt_d  = '0;
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else if (win_inc == WINDOW_C) begin
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_inc;
                        inv_cnt_d = inv_inc;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= HUNT;
            ofs_q     <= '0;
            sh_cnt_q  <= '0;
            win_cnt_q <= '0;
            inv_cnt_q <= '0;
            primed_q  <= 1'b0;
            prev_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ofs_q     <= ofs_d;
            sh_cnt_q  <= sh_cnt_d;
            win_cnt_q <= win_cnt_d;
            inv_cnt_q <= inv_cnt_d;
            primed_q  <= primed_d;
            prev_q    <= prev_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_block_lock  = (state_q == LOCKED);
    assign o_slip_offset = ofs_q;

endmodule
